// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: datapath width, sequential PC step and the
// two-state fetch FSM encoding.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   typedef enum logic {
      S_REQ  = 1'b0,
      S_WAIT = 1'b1
   } fetch_state_t;

   // Instruction fetches are always word aligned, so the low two bits are dropped.
   function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_buf.sv
// One-entry valid/ready holding register between instruction memory and decode.
// A flush beats a load, which beats a decode take.
module ifetch_buf
   import riscv_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_flush,
   input  logic            i_load,
   input  logic [XLEN-1:0] i_instr,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_take,
   output logic            o_valid,
   output logic [XLEN-1:0] o_instr,
   output logic [XLEN-1:0] o_pc
);

   logic            r_valid;
   logic [XLEN-1:0] r_instr;
   logic [XLEN-1:0] r_pc;

   // Payload is only written on an accepted load, so it holds its last value while empty.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc    <= '0;
      end else begin
         if (i_flush) begin
            r_valid <= 1'b0;
         end else if (i_load) begin
            r_valid <= 1'b1;
         end else if (i_take) begin
            r_valid <= 1'b0;
         end
         if (i_load && !i_flush) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_instr = r_instr;
   assign o_pc    = r_pc;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the PC, issues one outstanding word fetch at a time
// and hands the result to decode; a branch redirect kills in-flight and buffered work.
module ifetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_gnt,
   input  logic            i_imem_rvalid,
   input  logic [XLEN-1:0] i_imem_rdata,
   output logic            o_instr_valid,
   output logic [XLEN-1:0] o_instr,
   output logic [XLEN-1:0] o_instr_pc,
   input  logic            i_instr_ready
);

   fetch_state_t    r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_kill;

   logic            w_bufValid;
   logic            w_grant;
   logic            w_rsp;
   logic            w_load;
   logic            w_take;
   logic [XLEN-1:0] w_target;
   logic            w_unused;

   assign w_target = alignWord(i_redirect_pc);
   assign w_unused = &{1'b0, i_redirect_pc[1:0]};

   // A new request is only offered once decode has drained the buffer.
   assign o_imem_req  = (r_state == S_REQ) && !w_bufValid;
   assign o_imem_addr = r_pc;
   assign w_grant     = o_imem_req && i_imem_gnt;
   assign w_rsp       = (r_state == S_WAIT) && i_imem_rvalid;
   assign w_load      = w_rsp && !r_kill && !i_redirect;

   assign o_instr_valid = w_bufValid && !i_redirect;
   assign w_take        = o_instr_valid && i_instr_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_REQ;
         r_pc    <= RESET_PC;
         r_kill  <= 1'b0;
      end else if (i_redirect) begin
         r_pc <= w_target;
         case (r_state)
            S_REQ: begin
               if (w_grant) begin
                  r_state <= S_WAIT;
                  r_kill  <= 1'b1;
               end
            end
            S_WAIT: begin
               // A response landing in the redirect cycle is simply dropped.
               if (i_imem_rvalid) begin
                  r_state <= S_REQ;
                  r_kill  <= 1'b0;
               end else begin
                  r_kill <= 1'b1;
               end
            end
            default: r_state <= S_REQ;
         endcase
      end else begin
         case (r_state)
            S_REQ: begin
               if (w_grant) begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_imem_rvalid) begin
                  r_state <= S_REQ;
                  if (r_kill) begin
                     r_kill <= 1'b0;
                  end else begin
                     r_pc <= r_pc + PC_STEP;
                  end
               end
            end
            default: r_state <= S_REQ;
         endcase
      end
   end

   ifetch_buf u_buf (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (i_redirect),
      .i_load  (w_load),
      .i_instr (i_imem_rdata),
      .i_pc    (r_pc),
      .i_take  (w_take),
      .o_valid (w_bufValid),
      .o_instr (o_instr),
      .o_pc    (o_instr_pc)
   );

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus a randomized run
// against a memory model and an in-order expected-PC reference.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        o_instr_valid;
   logic [31:0] o_instr;
   logic [31:0] o_instr_pc;
   logic        ready;

   int nTests = 0;
   int nFail  = 0;

   // Memory model state used by the randomized run.
   logic        mPend;
   logic [31:0] mAddr;
   int          mCnt;

   ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_gnt    (gnt),
      .i_imem_rvalid (rvalid),
      .i_imem_rdata  (rdata),
      .o_instr_valid (o_instr_valid),
      .o_instr       (o_instr),
      .o_instr_pc    (o_instr_pc),
      .i_instr_ready (ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      redirect    = 1'b0;
      redirect_pc = '0;
      gnt         = 1'b0;
      rvalid      = 1'b0;
      rdata       = '0;
      ready       = 1'b1;
      mPend       = 1'b0;
      mAddr       = '0;
      mCnt        = 0;
      rst_n       = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Steers the PC from an idle S_REQ state with an empty buffer.
   task automatic gotoPc(input logic [31:0] a);
      redirect    = 1'b1;
      redirect_pc = a;
      gnt         = 1'b0;
      cyc();
      redirect = 1'b0;
   endtask

   task automatic test_reset();
      resetDut();
      #1;
      nTests++; if (o_imem_req !== 1'b1) begin nFail++; $display("[TB] FAIL rst_req: got %b want 1", o_imem_req); end
      nTests++; if (o_imem_addr !== 32'h0) begin nFail++; $display("[TB] FAIL rst_addr: got %h want 0", o_imem_addr); end
      nTests++; if (o_instr_valid !== 1'b0) begin nFail++; $display("[TB] FAIL rst_valid: got %b want 0", o_instr_valid); end
      nTests++; if (o_instr !== 32'h0) begin nFail++; $display("[TB] FAIL rst_instr: got %h want 0", o_instr); end
      nTests++; if (o_instr_pc !== 32'h0) begin nFail++; $display("[TB] FAIL rst_ipc: got %h want 0", o_instr_pc); end
   endtask

   task automatic test_sequential();
      logic [31:0] a;
      logic [31:0] d;
      resetDut();
      for (int k = 0; k < 3; k++) begin
         a   = 32'(k * 4);
         d   = $urandom;
         gnt = 1'b1;
         #1;
         nTests++; if (o_imem_req !== 1'b1 || o_imem_addr !== a) begin nFail++; $display("[TB] FAIL seq_req: got %b/%h want 1/%h", o_imem_req, o_imem_addr, a); end
         cyc();
         gnt = 1'b0; rvalid = 1'b1; rdata = d;
         #1;
         nTests++; if (o_imem_req !== 1'b0) begin nFail++; $display("[TB] FAIL seq_wait_req: got %b want 0", o_imem_req); end
         cyc();
         rvalid = 1'b0;
         #1;
         nTests++; if (o_instr_valid !== 1'b1) begin nFail++; $display("[TB] FAIL seq_valid: got %b want 1", o_instr_valid); end
         nTests++; if (o_instr !== d) begin nFail++; $display("[TB] FAIL seq_instr: got %h want %h", o_instr, d); end
         nTests++; if (o_instr_pc !== a) begin nFail++; $display("[TB] FAIL seq_ipc: got %h want %h", o_instr_pc, a); end
         cyc();
      end
      #1;
      nTests++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'hC) begin nFail++; $display("[TB] FAIL seq_next: got %b/%h want 1/c", o_imem_req, o_imem_addr); end
   endtask

   task automatic test_gnt_stall();
      logic [31:0] d;
      resetDut();
      gotoPc(32'h10);
      for (int k = 0; k < 3; k++) begin
         #1;
         nTests++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h10) begin nFail++; $display("[TB] FAIL stall_hold: got %b/%h want 1/10", o_imem_req, o_imem_addr); end
         cyc();
      end
      gnt = 1'b1;
      cyc();
      gnt = 1'b1;
      #1;
      nTests++; if (o_imem_req !== 1'b0) begin nFail++; $display("[TB] FAIL stall_single: got %b want 0", o_imem_req); end
      cyc();
      gnt = 1'b0; d = $urandom; rvalid = 1'b1; rdata = d;
      cyc();
      rvalid = 1'b0;
      #1;
      nTests++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 32'h10 || o_instr !== d) begin nFail++; $display("[TB] FAIL stall_data: got %b/%h/%h want 1/10/%h", o_instr_valid, o_instr_pc, o_instr, d); end
      cyc();
      #1;
      nTests++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h14) begin nFail++; $display("[TB] FAIL stall_next: got %b/%h want 1/14", o_imem_req, o_imem_addr); end
   endtask

   task automatic test_decode_stall();
      logic [31:0] d;
      resetDut();
      gotoPc(32'h40);
      ready = 1'b0; gnt = 1'b1;
      cyc();
      gnt = 1'b0; d = $urandom; rvalid = 1'b1; rdata = d;
      cyc();
      rvalid = 1'b0; rdata = $urandom;
      for (int k = 0; k < 4; k++) begin
         #1;
         nTests++; if (o_instr_valid !== 1'b1 || o_instr !== d || o_imem_req !== 1'b0) begin nFail++; $display("[TB] FAIL dstall_hold: got %b/%h/%b want 1/%h/0", o_instr_valid, o_instr, o_imem_req, d); end
         cyc();
      end
      ready = 1'b1;
      cyc();
      #1;
      nTests++; if (o_instr_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h44) begin nFail++; $display("[TB] FAIL dstall_next: got %b/%b/%h want 0/1/44", o_instr_valid, o_imem_req, o_imem_addr); end
   endtask

   task automatic test_redirect_wait();
      resetDut();
      gotoPc(32'h20);
      gnt = 1'b1;
      cyc();
      gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h103;
      cyc();
      redirect = 1'b0;
      #1;
      nTests++; if (o_imem_req !== 1'b0) begin nFail++; $display("[TB] FAIL rdw_kill_req: got %b want 0", o_imem_req); end
      rvalid = 1'b1; rdata = $urandom;
      cyc();
      rvalid = 1'b0;
      #1;
      nTests++; if (o_instr_valid !== 1'b0) begin nFail++; $display("[TB] FAIL rdw_dropped: got %b want 0", o_instr_valid); end
      nTests++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h100) begin nFail++; $display("[TB] FAIL rdw_newreq: got %b/%h want 1/100", o_imem_req, o_imem_addr); end
   endtask

   task automatic test_redirect_collide();
      resetDut();
      gotoPc(32'h30);
      gnt = 1'b1;
      cyc();
      gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h200; rvalid = 1'b1; rdata = $urandom;
      #1;
      nTests++; if (o_instr_valid !== 1'b0) begin nFail++; $display("[TB] FAIL rdc_rv_valid: got %b want 0", o_instr_valid); end
      cyc();
      redirect = 1'b0; rvalid = 1'b0;
      #1;
      nTests++; if (o_instr_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h200) begin nFail++; $display("[TB] FAIL rdc_rv_next: got %b/%b/%h want 0/1/200", o_instr_valid, o_imem_req, o_imem_addr); end
      ready = 1'b0; gnt = 1'b1;
      cyc();
      gnt = 1'b0; rvalid = 1'b1; rdata = $urandom;
      cyc();
      rvalid = 1'b0;
      #1;
      nTests++; if (o_instr_valid !== 1'b1) begin nFail++; $display("[TB] FAIL rdc_buf_full: got %b want 1", o_instr_valid); end
      redirect = 1'b1; redirect_pc = 32'h300; ready = 1'b1;
      #1;
      nTests++; if (o_instr_valid !== 1'b0) begin nFail++; $display("[TB] FAIL rdc_buf_mask: got %b want 0", o_instr_valid); end
      cyc();
      redirect = 1'b0;
      #1;
      nTests++; if (o_instr_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h300) begin nFail++; $display("[TB] FAIL rdc_buf_next: got %b/%b/%h want 0/1/300", o_instr_valid, o_imem_req, o_imem_addr); end
   endtask

   task automatic test_wrap();
      resetDut();
      gotoPc(32'hFFFF_FFFF);
      #1;
      nTests++; if (o_imem_addr !== 32'hFFFF_FFFC) begin nFail++; $display("[TB] FAIL wrap_align: got %h want fffffffc", o_imem_addr); end
      gnt = 1'b1;
      cyc();
      gnt = 1'b0; rvalid = 1'b1; rdata = $urandom;
      cyc();
      rvalid = 1'b0;
      #1;
      nTests++; if (o_instr_pc !== 32'hFFFF_FFFC) begin nFail++; $display("[TB] FAIL wrap_ipc: got %h want fffffffc", o_instr_pc); end
      cyc();
      #1;
      nTests++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin nFail++; $display("[TB] FAIL wrap_next: got %b/%h want 1/0", o_imem_req, o_imem_addr); end
   endtask

   task automatic test_reset_midfetch();
      logic [31:0] d;
      resetDut();
      gotoPc(32'h50);
      gnt = 1'b1;
      cyc();
      gnt = 1'b0;
      #1;
      nTests++; if (o_imem_req !== 1'b0) begin nFail++; $display("[TB] FAIL rmf_wait: got %b want 0", o_imem_req); end
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
      nTests++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin nFail++; $display("[TB] FAIL rmf_async: got %b/%h want 1/0", o_imem_req, o_imem_addr); end
      cyc();
      rvalid = 1'b1; rdata = $urandom;
      cyc();
      rvalid = 1'b0;
      #1;
      nTests++; if (o_instr_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin nFail++; $display("[TB] FAIL rmf_late: got %b/%b/%h want 0/1/0", o_instr_valid, o_imem_req, o_imem_addr); end
      gnt = 1'b1;
      cyc();
      gnt = 1'b0; d = $urandom; rvalid = 1'b1; rdata = d;
      cyc();
      rvalid = 1'b0;
      #1;
      nTests++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 32'h0 || o_instr !== d) begin nFail++; $display("[TB] FAIL rmf_restart: got %b/%h/%h want 1/0/%h", o_instr_valid, o_instr_pc, o_instr, d); end
      cyc();
   endtask

   // Randomized traffic: instructions must reach decode in program order, with
   // the expected PC restarting at every redirect target.
   task automatic test_random();
      logic [31:0] expPc;
      logic [31:0] prevAddr;
      logic [31:0] sAddr;
      logic        prevReqNoGnt;
      logic        prevRedir;
      logic        hsMem;
      logic        rvNow;
      int          nHs;
      resetDut();
      expPc = 32'h0; prevReqNoGnt = 1'b0; prevRedir = 1'b0; prevAddr = '0; nHs = 0;
      for (int c = 0; c < 2000; c++) begin
         ready       = ($urandom_range(99) < 70);
         redirect    = ($urandom_range(99) < 5);
         redirect_pc = $urandom;
         gnt         = ($urandom_range(99) < 60);
         rvalid      = mPend && (mCnt == 0);
         rdata       = rvalid ? memWord(mAddr) : $urandom;
         #1;
         nTests++; if (o_imem_req && mPend) begin nFail++; $display("[TB] FAIL rnd_outstanding: cycle %0d req while fetch pending", c); end
         if (prevReqNoGnt && !prevRedir) begin
            nTests++; if (o_imem_req !== 1'b1 || o_imem_addr !== prevAddr) begin nFail++; $display("[TB] FAIL rnd_addr_stable: got %b/%h want 1/%h", o_imem_req, o_imem_addr, prevAddr); end
         end
         if (redirect) begin
            nTests++; if (o_instr_valid !== 1'b0) begin nFail++; $display("[TB] FAIL rnd_redir_valid: got %b want 0", o_instr_valid); end
         end
         if (o_instr_valid && ready) begin
            nHs++;
            nTests++; if (o_instr_pc !== expPc) begin nFail++; $display("[TB] FAIL rnd_ipc: got %h want %h", o_instr_pc, expPc); end
            nTests++; if (o_instr !== memWord(expPc)) begin nFail++; $display("[TB] FAIL rnd_instr: got %h want %h", o_instr, memWord(expPc)); end
            expPc = expPc + 32'd4;
         end
         if (redirect) expPc = redirect_pc & 32'hFFFF_FFFC;
         prevReqNoGnt = o_imem_req && !gnt;
         prevAddr     = o_imem_addr;
         prevRedir    = redirect;
         hsMem        = o_imem_req && gnt;
         sAddr        = o_imem_addr;
         rvNow        = rvalid;
         cyc();
         if (rvNow) mPend = 1'b0;
         else if (mPend && mCnt > 0) mCnt--;
         if (hsMem) begin
            mPend = 1'b1;
            mAddr = sAddr;
            mCnt  = $urandom_range(3, 0);
         end
      end
      redirect = 1'b0;
      nTests++; if (nHs < 50) begin nFail++; $display("[TB] FAIL rnd_progress: got %0d handshakes want >= 50", nHs); end
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_sequential();
      test_gnt_stall();
      test_decode_stall();
      test_redirect_wait();
      test_redirect_collide();
      test_wrap();
      test_reset_midfetch();
      test_random();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
